mem_port_arbiter: RTL and testbench

Sequences the single shared memory port between the instruction-fetch stage (read-only requester) and the memory-access stage (read/write requester). Sits between the pipeline stages and the memory model. Applies fixed priority with a starvation guard for fetch, runs one transaction at a time with a req/ack handshake on each side, and aborts a transaction that does not complete within a cycle budget.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_timer.sv | 29 ++
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states,
// access-length codes, owner encoding and the fetch starvation counter update.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  // Counts consecutive MEM wins that left a fetch waiting; saturates at 15.
  function automatic logic [3:0] starve_upd(input logic [3:0] cnt,
                                            input logic       grant_mem,
                                            input logic       if_waiting);
    if (!grant_mem || !if_waiting) return 4'd0;
    return (cnt == 4'hF) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle counter for the arbiter; expire_o flags the last cycle of the
// transaction budget.
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign expire_o = (cnt_q == 8'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                 cnt_d = 8'd0;
    else if (en_i && !expire_o) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (read-only) and the
// memory-access stage, one transaction at a time, with a timeout abort.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MADDR_L     = 32,
  parameter int DATA_L      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               if_req,
  input  logic [MADDR_L-1:0] if_addr,
  input  logic [1:0]         if_len,
  output logic               if_ack,
  output logic [DATA_L-1:0]  if_rdata,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [MADDR_L-1:0] mem_addr,
  input  logic [1:0]         mem_len,
  input  logic [DATA_L-1:0]  mem_wdata,
  output logic               mem_ack,
  output logic [DATA_L-1:0]  mem_rdata,
  output logic [MADDR_L-1:0] m_addr,
  output logic               m_re,
  output logic               m_we,
  output logic [1:0]         m_len,
  output logic [DATA_L-1:0]  m_wdata,
  input  logic [DATA_L-1:0]  m_rdata,
  input  logic               m_ready,
  output logic               err
);

  arb_state_e         state_q;
  logic               owner_q;
  logic [3:0]         starve_q;
  logic [MADDR_L-1:0] m_addr_q;
  logic               m_re_q;
  logic               m_we_q;
  logic [1:0]         m_len_q;
  logic [DATA_L-1:0]  m_wdata_q;
  logic               if_ack_q;
  logic               mem_ack_q;
  logic [DATA_L-1:0]  if_rdata_q;
  logic [DATA_L-1:0]  mem_rdata_q;
  logic               err_q;

  logic               grant_any_d;
  logic               grant_mem_d;
  logic               finish_d;
  logic [DATA_L-1:0]  rdata_d;
  logic               tmo_expire;

  assign grant_any_d = if_req | mem_req;
  // MEM has priority unless fetch has already lost STARVE_MAX times in a row.
  assign grant_mem_d = mem_req & ~(if_req & (starve_q == 4'(STARVE_MAX)));
  // m_ready on the expiry edge still counts as a normal completion.
  assign finish_d    = m_ready | tmo_expire;
  assign rdata_d     = m_ready ? m_rdata : '0;

  mem_arb_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q != BUSY),
    .en_i    ((state_q == BUSY) & ~m_ready),
    .expire_o(tmo_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      starve_q    <= 4'd0;
      m_addr_q    <= '0;
      m_re_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_len_q     <= 2'd0;
      m_wdata_q   <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_any_d) begin
            owner_q  <= grant_mem_d ? OWN_MEM : OWN_IF;
            starve_q <= starve_upd(starve_q, grant_mem_d, if_req);
            m_addr_q <= grant_mem_d ? mem_addr : if_addr;
            m_len_q  <= grant_mem_d ? mem_len : if_len;
            if (grant_mem_d) m_wdata_q <= mem_wdata;
            m_we_q   <= grant_mem_d & mem_we;
            m_re_q   <= ~(grant_mem_d & mem_we);
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (finish_d) begin
            m_re_q  <= 1'b0;
            m_we_q  <= 1'b0;
            err_q   <= ~m_ready;
            state_q <= DONE;
            if (owner_q == OWN_MEM) begin
              mem_ack_q <= 1'b1;
              if (m_re_q) mem_rdata_q <= rdata_d;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= rdata_d;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_addr    = m_addr_q;
  assign m_re      = m_re_q;
  assign m_we      = m_we_q;
  assign m_len     = m_len_q;
  assign m_wdata   = m_wdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: requesters and memory are
// modelled behaviourally, expected transactions are queued at grant time.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int SMAX  = 4;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Requester side 0 = IF, side 1 = MEM
  logic        r_req[2];
  logic [31:0] r_addr[2];
  logic [1:0]  r_len[2];
  logic        r_we[2];
  logic [31:0] r_wdata[2];

  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [1:0]  if_len, mem_len;
  assign if_req    = r_req[0];
  assign if_addr   = r_addr[0];
  assign if_len    = r_len[0];
  assign mem_req   = r_req[1];
  assign mem_we    = r_we[1];
  assign mem_addr  = r_addr[1];
  assign mem_len   = r_len[1];
  assign mem_wdata = r_wdata[1];

  logic        if_ack, mem_ack, m_re, m_we, err;
  logic [31:0] if_rdata, mem_rdata, m_addr, m_wdata;
  logic [1:0]  m_len;
  logic [31:0] m_rdata = 32'h0;
  logic        m_ready = 1'b0;

  mem_port_arbiter #(
    .MADDR_L(32), .DATA_L(32), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_len(if_len),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_len(m_len), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  typedef struct {
    logic [31:0] addr; logic [1:0] len; logic we; logic [31:0] wdata;
    int delay; int hold;
  } txn_t;

  typedef struct {
    logic own_mem; logic we; logic [31:0] addr; logic [1:0] len;
    logic [31:0] wdata; logic [31:0] rdata; logic err; int ack_cyc;
  } exp_t;

  exp_t        sb[$];
  txn_t        dir_if[$], dir_mem[$];
  int          dir_lat[$];
  logic [31:0] dir_dat[$];

  int   st[2], dly[2], cur_hold[2];
  txn_t nxt[2];
  bit   en[2];
  int   mode = 0;

  // Reference model state
  bit          busy_model = 1'b0;
  int          cur_ack = 0, rdy_cyc = -1, idle_from = 0, starve_m = 0;
  logic [31:0] mem_rd = 32'h0;
  logic        prev_act = 1'b0;
  logic [31:0] exp_if_rd = 32'h0, exp_mem_rd = 32'h0;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic txn_t rand_txn(input int side);
    txn_t t;
    t.addr = $urandom;
    case ($urandom_range(0, 2))
      0:       t.len = LEN_B;
      1:       t.len = LEN_H;
      default: t.len = LEN_W;
    endcase
    t.we    = (side == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    t.wdata = $urandom;
    t.delay = (mode == 1) ? 0 : int'($urandom_range(0, 3));
    t.hold  = (mode == 1) ? 0 : int'($urandom_range(0, 2));
    return t;
  endfunction

  function automatic txn_t next_txn(input int side);
    if (side == 0 && dir_if.size() > 0)  return dir_if.pop_front();
    if (side == 1 && dir_mem.size() > 0) return dir_mem.pop_front();
    return rand_txn(side);
  endfunction

  function automatic int pick_lat();
    if (dir_lat.size() > 0) return dir_lat.pop_front();
    case ($urandom_range(0, 9))
      0, 1, 2: return 1;
      3, 4:    return 2;
      5:       return 3;
      6:       return 5;
      7:       return TMO - 1;
      8:       return TMO;
      default: return NEVER;
    endcase
  endfunction

  task automatic apply(input int side, input txn_t t);
    r_addr[side]   = t.addr;
    r_len[side]    = t.len;
    r_we[side]     = t.we;
    r_wdata[side]  = t.wdata;
    cur_hold[side] = t.hold;
  endtask

  task automatic drop(input int side);
    r_req[side] = 1'b0;
    nxt[side]   = next_txn(side);
    st[side]    = 0;
    dly[side]   = nxt[side].delay;
  endtask

  // st: 0 waiting to issue, 1 requesting, 2 holding req one extra cycle
  task automatic req_step(input int side, input logic ack);
    case (st[side])
      1: if (ack) begin
        if (cur_hold[side] == 2 && en[side]) apply(side, next_txn(side));
        else if (cur_hold[side] == 1) st[side] = 2;
        else drop(side);
      end
      2: drop(side);
      default: if (en[side]) begin
        if (dly[side] == 0) begin
          apply(side, nxt[side]);
          r_req[side] = 1'b1;
          st[side]    = 1;
        end else dly[side]--;
      end
    endcase
  endtask

  task automatic tick();
    logic act, exp_g;
    exp_t e;
    int   lat, w;
    logic [31:0] rd;
    @(posedge clk); #1;
    act = (m_re | m_we) & ~prev_act;
    prev_act = m_re | m_we;
    if (busy_model && cyc == cur_ack) begin
      busy_model = 1'b0;
      idle_from  = cyc + 2;
    end
    exp_g = !busy_model && cyc >= idle_from && (r_req[0] || r_req[1]);
    if (exp_g || act) chk("grant", 32'(act), 32'(exp_g));
    if (exp_g) begin
      e.own_mem = r_req[1] && !(r_req[0] && starve_m == SMAX);
      if (e.own_mem && r_req[0]) starve_m = (starve_m < 15) ? starve_m + 1 : 15;
      else starve_m = 0;
      w       = e.own_mem ? 1 : 0;
      e.we    = e.own_mem ? r_we[1] : 1'b0;
      e.addr  = r_addr[w];
      e.len   = r_len[w];
      e.wdata = r_wdata[w];
      lat     = pick_lat();
      rd      = (dir_dat.size() > 0) ? dir_dat.pop_front() : $urandom;
      e.err   = (lat > TMO);
      e.rdata = e.err ? 32'h0 : rd;
      e.ack_cyc = cyc + (e.err ? TMO : lat);
      sb.push_back(e);
      busy_model = 1'b1;
      cur_ack    = e.ack_cyc;
      rdy_cyc    = e.err ? -1 : cyc + lat;
      mem_rd     = rd;
      // Requester changes its fields while its request is in flight
      r_addr[w]  = $urandom;
      r_wdata[w] = $urandom;
      r_len[w]   = 2'($urandom_range(0, 3));
    end
    req_step(0, if_ack);
    req_step(1, mem_ack);
    if (busy_model) begin
      m_ready = (cyc + 1 == rdy_cyc);
      m_rdata = mem_rd;
    end else begin
      m_ready = 1'($urandom_range(0, 1));
      m_rdata = $urandom;
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, 32'({if_ack, mem_ack, err, m_re, m_we}), 32'h0);
    chk({nm, "_addr"}, m_addr, 32'h0);
    chk({nm, "_len"}, 32'(m_len), 32'h0);
    chk({nm, "_wdata"}, m_wdata, 32'h0);
    chk({nm, "_if_rdata"}, if_rdata, 32'h0);
    chk({nm, "_mem_rdata"}, mem_rdata, 32'h0);
  endtask

  // Monitor: pops the scoreboard whenever the expected transaction completes
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) continue;
      if (sb.size() == 0) begin
        chk("idle_outputs", 32'({if_ack, mem_ack, err, m_re, m_we}), 32'h0);
      end else if (cyc < sb[0].ack_cyc) begin
        chk("busy_ctl", 32'({if_ack, mem_ack, err, m_re, m_we}),
            32'({3'b000, ~sb[0].we, sb[0].we}));
        chk("busy_addr", m_addr, sb[0].addr);
      end else begin
        e = sb.pop_front();
        chk("ack_ctl", 32'({if_ack, mem_ack, err, m_re, m_we}),
            32'({~e.own_mem, e.own_mem, e.err, 2'b00}));
        chk("ack_addr", m_addr, e.addr);
        chk("ack_len", 32'(m_len), 32'(e.len));
        if (e.we) chk("ack_wdata", m_wdata, e.wdata);
        if (!e.own_mem) exp_if_rd = e.rdata;
        else if (!e.we) exp_mem_rd = e.rdata;
        chk("if_rdata", if_rdata, exp_if_rd);
        chk("mem_rdata", mem_rdata, exp_mem_rd);
      end
    end
  end

  initial begin : stim
    for (int s = 0; s < 2; s++) begin
      r_req[s] = 1'b0; r_addr[s] = 32'h0; r_len[s] = 2'd0;
      r_we[s] = 1'b0; r_wdata[s] = 32'h0; en[s] = 1'b1;
    end
    dir_if.push_back(txn_t'{addr:32'h40, len:LEN_W, we:1'b0, wdata:32'h0, delay:0, hold:0});
    dir_if.push_back(txn_t'{addr:32'h44, len:LEN_H, we:1'b0, wdata:32'h0, delay:10, hold:0});
    dir_mem.push_back(txn_t'{addr:32'h100, len:LEN_W, we:1'b1, wdata:32'hDEADBEEF, delay:6, hold:1});
    dir_mem.push_back(txn_t'{addr:32'h104, len:LEN_W, we:1'b0, wdata:32'h0, delay:8, hold:2});
    dir_mem.push_back(txn_t'{addr:32'h108, len:LEN_B, we:1'b1, wdata:32'h55AA55AA, delay:0, hold:0});
    dir_lat.push_back(2);     dir_dat.push_back(32'h12345678);
    dir_lat.push_back(1);     dir_dat.push_back(32'hCAFEF00D);
    dir_lat.push_back(NEVER); dir_dat.push_back(32'hBADBAD00);
    dir_lat.push_back(TMO);   dir_dat.push_back(32'h0BADCAFE);
    for (int s = 0; s < 2; s++) begin
      nxt[s] = next_txn(s); st[s] = 0; dly[s] = nxt[s].delay;
    end

    #2 rst_n = 1'b0;
    #10 check_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    idle_from = cyc + 1;

    for (int i = 0; i < 80; i++) tick();
    mode = 1;
    for (int i = 0; i < 200; i++) tick();
    mode = 0;
    for (int i = 0; i < 1500; i++) tick();

    // Drain, then abort a fetch in flight with reset
    en[0] = 1'b0; en[1] = 1'b0;
    for (int i = 0; i < 100 && !(sb.size() == 0 && !busy_model && st[0] == 0 && st[1] == 0); i++)
      tick();
    chk("drain", 32'(sb.size()), 32'h0);
    dir_lat.delete(); dir_dat.delete();
    dir_lat.push_back(NEVER);
    nxt[0] = txn_t'{addr:32'h200, len:LEN_W, we:1'b0, wdata:32'h0, delay:0, hold:0};
    dly[0] = 0; en[0] = 1'b1;
    for (int i = 0; i < 20 && !busy_model; i++) tick();
    chk("pre_reset_grant", 32'(busy_model), 32'h1);
    en[0] = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    sb.delete();
    busy_model = 1'b0; starve_m = 0; prev_act = 1'b0;
    exp_if_rd = 32'h0; exp_mem_rd = 32'h0;
    m_ready = 1'b0;
    #1 check_zero("mid_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_zero("in_reset");
      chk("in_reset_req", 32'(if_req), 32'h1);
    end
    rst_n = 1'b1;
    idle_from = cyc + 1;
    dir_lat.push_back(2);
    for (int i = 0; i < 30; i++) tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
